alu_control: RTL and testbench

- ALU control decoder for the 16-bit MIPS-style datapath.
- Maps the 4-bit main-control opcode class (AluOP) and the 6-bit R-type function field (func) to a 3-bit ALU operation select.
- Also produces side flags: jump-register, shift, and illegal-encoding.
- All outputs are registered: one cycle of latency between the ALU-control stage and the ALU.

---
 rtl/alu_control.sv | 98 +++++++++
 tb/tb_alu_control.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/alu_control.sv
// ALU control decoder: maps the main-control operation class and the R-type
// function field to a registered 3-bit ALU select plus jr/shift/illegal flags.
module alu_control (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] AluOP,
   input  logic [5:0] func,
   output logic [2:0] AluControlSignal,
   output logic       is_jr,
   output logic       is_shift,
   output logic       illegal
);

   localparam logic [2:0] SEL_ADD = 3'b000;
   localparam logic [2:0] SEL_SUB = 3'b001;
   localparam logic [2:0] SEL_AND = 3'b010;
   localparam logic [2:0] SEL_OR  = 3'b011;
   localparam logic [2:0] SEL_SLT = 3'b100;
   localparam logic [2:0] SEL_SLL = 3'b101;
   localparam logic [2:0] SEL_SRL = 3'b110;

   localparam logic [3:0] OP_RTYPE = 4'b0000;
   localparam logic [3:0] OP_ADDI  = 4'b0001;
   localparam logic [3:0] OP_LW    = 4'b0010;
   localparam logic [3:0] OP_SW    = 4'b0011;
   localparam logic [3:0] OP_BEQ   = 4'b0100;
   localparam logic [3:0] OP_BNE   = 4'b0101;
   localparam logic [3:0] OP_SLTI  = 4'b0110;
   localparam logic [3:0] OP_J     = 4'b0111;
   localparam logic [3:0] OP_JAL   = 4'b1000;
   localparam logic [3:0] OP_ANDI  = 4'b1001;
   localparam logic [3:0] OP_ORI   = 4'b1010;

   localparam logic [5:0] FN_ADD = 6'b100000;
   localparam logic [5:0] FN_SUB = 6'b100010;
   localparam logic [5:0] FN_AND = 6'b100100;
   localparam logic [5:0] FN_OR  = 6'b100101;
   localparam logic [5:0] FN_SLT = 6'b101010;
   localparam logic [5:0] FN_SLL = 6'b000000;
   localparam logic [5:0] FN_SRL = 6'b000010;
   localparam logic [5:0] FN_JR  = 6'b001000;

   logic [2:0] aluSelNext;
   logic       isJrNext;
   logic       isShiftNext;
   logic       illegalNext;

   // func is only examined inside the R-type branch, so an unknown func on
   // I/J-type instructions can never reach the registers.
   always_comb begin
      aluSelNext  = SEL_ADD;
      isJrNext    = 1'b0;
      isShiftNext = 1'b0;
      illegalNext = 1'b0;
      case (AluOP)
         OP_RTYPE: begin
            case (func)
               FN_ADD:  aluSelNext = SEL_ADD;
               FN_SUB:  aluSelNext = SEL_SUB;
               FN_AND:  aluSelNext = SEL_AND;
               FN_OR:   aluSelNext = SEL_OR;
               FN_SLT:  aluSelNext = SEL_SLT;
               FN_SLL: begin
                  aluSelNext  = SEL_SLL;
                  isShiftNext = 1'b1;
               end
               FN_SRL: begin
                  aluSelNext  = SEL_SRL;
                  isShiftNext = 1'b1;
               end
               FN_JR:   isJrNext    = 1'b1;
               default: illegalNext = 1'b1;
            endcase
         end
         OP_ADDI, OP_LW, OP_SW, OP_J, OP_JAL: aluSelNext = SEL_ADD;
         OP_BEQ, OP_BNE:                      aluSelNext = SEL_SUB;
         OP_SLTI:                             aluSelNext = SEL_SLT;
         OP_ANDI:                             aluSelNext = SEL_AND;
         OP_ORI:                              aluSelNext = SEL_OR;
         default:                             illegalNext = 1'b1;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         AluControlSignal <= SEL_ADD;
         is_jr            <= 1'b0;
         is_shift         <= 1'b0;
         illegal          <= 1'b0;
      end else begin
         AluControlSignal <= aluSelNext;
         is_jr            <= isJrNext;
         is_shift         <= isShiftNext;
         illegal          <= illegalNext;
      end
   end

endmodule

// File: tb/tb_alu_control.sv
// Testbench for alu_control: table-driven decode vectors through a scoreboard
// queue, plus directed reset, latency and mid-stream reset sequences.
module tb_alu_control;

   logic       clk;
   logic       rst_n;
   logic [3:0] AluOP;
   logic [5:0] func;
   logic [2:0] AluControlSignal;
   logic       is_jr;
   logic       is_shift;
   logic       illegal;

   alu_control dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .AluOP            (AluOP),
      .func             (func),
      .AluControlSignal (AluControlSignal),
      .is_jr            (is_jr),
      .is_shift         (is_shift),
      .illegal          (illegal)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [2:0] sel;
      logic       jr;
      logic       sh;
      logic       ill;
   } exp_t;

   typedef struct {
      string      name;
      logic [3:0] op;
      logic [5:0] fn;
      exp_t       exp;
   } vec_t;

   localparam int NVEC = 27;

   vec_t vecs [NVEC];
   exp_t expQ [$];
   int   asserts = 0;
   int   fails   = 0;

   task automatic pushExp(input logic [2:0] sel, input logic jr, input logic sh, input logic ill);
      exp_t e;
      e.sel = sel;
      e.jr  = jr;
      e.sh  = sh;
      e.ill = ill;
      expQ.push_back(e);
   endtask

   task automatic checkExp(input string name);
      exp_t e;
      exp_t got;
      got = {AluControlSignal, is_jr, is_shift, illegal};
      asserts++;
      if (expQ.size() == 0) begin
         fails++;
         $display("FAIL %s: scoreboard empty, got sel=%b jr=%b shift=%b illegal=%b",
                  name, got.sel, got.jr, got.sh, got.ill);
      end else begin
         e = expQ.pop_front();
         if (got !== e) begin
            fails++;
            $display("FAIL %s: got sel=%b jr=%b shift=%b illegal=%b, expected sel=%b jr=%b shift=%b illegal=%b",
                     name, got.sel, got.jr, got.sh, got.ill, e.sel, e.jr, e.sh, e.ill);
         end else begin
            $display("ok   %s: sel=%b jr=%b shift=%b illegal=%b",
                     name, got.sel, got.jr, got.sh, got.ill);
         end
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   initial begin
      vecs[0]  = '{"r_add",    4'b0000, 6'b100000, '{3'b000, 1'b0, 1'b0, 1'b0}};
      vecs[1]  = '{"r_sub",    4'b0000, 6'b100010, '{3'b001, 1'b0, 1'b0, 1'b0}};
      vecs[2]  = '{"r_and",    4'b0000, 6'b100100, '{3'b010, 1'b0, 1'b0, 1'b0}};
      vecs[3]  = '{"r_or",     4'b0000, 6'b100101, '{3'b011, 1'b0, 1'b0, 1'b0}};
      vecs[4]  = '{"r_slt",    4'b0000, 6'b101010, '{3'b100, 1'b0, 1'b0, 1'b0}};
      vecs[5]  = '{"r_sll",    4'b0000, 6'b000000, '{3'b101, 1'b0, 1'b1, 1'b0}};
      vecs[6]  = '{"r_srl",    4'b0000, 6'b000010, '{3'b110, 1'b0, 1'b1, 1'b0}};
      vecs[7]  = '{"r_jr",     4'b0000, 6'b001000, '{3'b000, 1'b1, 1'b0, 1'b0}};
      vecs[8]  = '{"i_addi",   4'b0001, 6'bxxxxxx, '{3'b000, 1'b0, 1'b0, 1'b0}};
      vecs[9]  = '{"i_lw",     4'b0010, 6'bxxxxxx, '{3'b000, 1'b0, 1'b0, 1'b0}};
      vecs[10] = '{"i_sw",     4'b0011, 6'bxxxxxx, '{3'b000, 1'b0, 1'b0, 1'b0}};
      vecs[11] = '{"i_beq",    4'b0100, 6'bxxxxxx, '{3'b001, 1'b0, 1'b0, 1'b0}};
      vecs[12] = '{"i_bne",    4'b0101, 6'bxxxxxx, '{3'b001, 1'b0, 1'b0, 1'b0}};
      vecs[13] = '{"i_slti",   4'b0110, 6'bxxxxxx, '{3'b100, 1'b0, 1'b0, 1'b0}};
      vecs[14] = '{"j_j",      4'b0111, 6'bxxxxxx, '{3'b000, 1'b0, 1'b0, 1'b0}};
      vecs[15] = '{"j_jal",    4'b1000, 6'bxxxxxx, '{3'b000, 1'b0, 1'b0, 1'b0}};
      vecs[16] = '{"i_andi",   4'b1001, 6'bxxxxxx, '{3'b010, 1'b0, 1'b0, 1'b0}};
      vecs[17] = '{"i_ori",    4'b1010, 6'bxxxxxx, '{3'b011, 1'b0, 1'b0, 1'b0}};
      vecs[18] = '{"ill_func", 4'b0000, 6'b111111, '{3'b000, 1'b0, 1'b0, 1'b1}};
      vecs[19] = '{"ill_1100", 4'b1100, 6'bxxxxxx, '{3'b000, 1'b0, 1'b0, 1'b1}};
      vecs[20] = '{"ill_1011", 4'b1011, 6'b000000, '{3'b000, 1'b0, 1'b0, 1'b1}};
      vecs[21] = '{"ill_1101", 4'b1101, 6'b001000, '{3'b000, 1'b0, 1'b0, 1'b1}};
      vecs[22] = '{"ill_1111", 4'b1111, 6'b100010, '{3'b000, 1'b0, 1'b0, 1'b1}};
      vecs[23] = '{"ill_1110", 4'b1110, 6'b101010, '{3'b000, 1'b0, 1'b0, 1'b1}};
      vecs[24] = '{"ill_f1",   4'b0000, 6'b000001, '{3'b000, 1'b0, 1'b0, 1'b1}};
      vecs[25] = '{"addi_fsrl",4'b0001, 6'b000010, '{3'b000, 1'b0, 1'b0, 1'b0}};
      vecs[26] = '{"ori_fjr",  4'b1010, 6'b001000, '{3'b011, 1'b0, 1'b0, 1'b0}};

      // Reset held across an edge, then released
      rst_n = 1'b0;
      AluOP = 4'b0000;
      func  = 6'b100010;
      #12;
      pushExp(3'b000, 1'b0, 1'b0, 1'b0);
      checkExp("reset_hold");
      @(negedge clk);
      rst_n = 1'b1;
      pushExp(3'b001, 1'b0, 1'b0, 1'b0);
      @(posedge clk);
      #1;
      checkExp("reset_release");

      for (int i = 0; i < NVEC; i++) begin
         @(negedge clk);
         AluOP = vecs[i].op;
         func  = vecs[i].fn;
         expQ.push_back(vecs[i].exp);
         @(posedge clk);
         #1;
         checkExp(vecs[i].name);
      end

      // Input change between edges must not show until the next edge
      @(negedge clk);
      AluOP = 4'b1001;
      func  = 6'bxxxxxx;
      pushExp(3'b010, 1'b0, 1'b0, 1'b0);
      @(posedge clk);
      #1;
      checkExp("lat_andi");
      #1;
      AluOP = 4'b1010;
      pushExp(3'b010, 1'b0, 1'b0, 1'b0);
      #2;
      checkExp("lat_hold");
      pushExp(3'b011, 1'b0, 1'b0, 1'b0);
      @(posedge clk);
      #1;
      checkExp("lat_ori");

      // Asynchronous reset between edges while output is srl
      @(negedge clk);
      AluOP = 4'b0000;
      func  = 6'b000010;
      pushExp(3'b110, 1'b0, 1'b1, 1'b0);
      @(posedge clk);
      #1;
      checkExp("pre_async_srl");
      #2;
      rst_n = 1'b0;
      pushExp(3'b000, 1'b0, 1'b0, 1'b0);
      #1;
      checkExp("async_reset");
      @(posedge clk);
      #1;
      pushExp(3'b000, 1'b0, 1'b0, 1'b0);
      checkExp("reset_edge_hold");
      @(negedge clk);
      rst_n = 1'b1;
      pushExp(3'b110, 1'b0, 1'b1, 1'b0);
      @(posedge clk);
      #1;
      checkExp("post_reset_srl");

      if (expQ.size() != 0) begin
         asserts++;
         fails++;
         $display("FAIL scoreboard_drain: %0d entries left, expected 0", expQ.size());
      end

      $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
      $finish;
   end

endmodule
